// File: rtl/exec_pkg.sv
// Shared definitions for the exec_unit slice: opcodes, instruction layout, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package exec_pkg;

    localparam int INSTR_WIDTH = 16;

    // ALU opcode map
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_CMP = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

    // Instruction word, MSB first: [15:13] op, [12:11] rd/rsA, [10:9] rsB, [8] imm_sel, [7:0] imm
    typedef struct packed {
        op_e        op;
        logic [1:0] rd;
        logic [1:0] rsb;
        logic       imm_sel;
        logic [7:0] imm;
    } instr_t;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

endpackage

// File: rtl/alu.sv
// Unsigned ALU: add/sub/logic/compare/shift with carry and compare outputs.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module alu
    import exec_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int OPCODE_WIDTH = 3
) (
    input  logic [OPCODE_WIDTH-1:0] op,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    output logic [WIDTH-1:0]        y,
    output logic                    carry,
    output logic                    gt,
    output logic                    eq
);

    op_e            op_sel;
    logic [WIDTH:0] sum;

    assign op_sel = op_e'(op);
    assign sum    = {1'b0, a} + {1'b0, b};
    assign gt     = (a > b);
    assign eq     = (a == b);

    // Operation select; carry is only meaningful for ADD. Logical shifts by
    // WIDTH or more already produce zero, which is the intended behaviour.
    always_comb begin
        y     = '0;
        carry = 1'b0;
        case (op_sel)
            OP_ADD: begin
                y     = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_CMP:  y = a - b;
            OP_SHL:  y = a << b;
            OP_SHR:  y = a >> b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/exec_unit.sv
// Single-issue execute unit: 4-entry register file, operand latch, ALU, write-back.
// Latency: accept at edge N -> registered done/result/regs at edge N+2; next accept at N+3.
// Backpressure: instr_ready only in IDLE; instr_valid elsewhere is ignored, nothing queued.
module exec_unit
    import exec_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int OPCODE_WIDTH = 3,
    parameter int NREGS        = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [INSTR_WIDTH-1:0] instr,
    output logic                   done,
    output logic [WIDTH-1:0]       result,
    output logic [2:0]             flags,
    input  logic [1:0]             dbg_addr,
    output logic [WIDTH-1:0]       dbg_data
);

    state_e                  state;
    state_e                  state_nxt;
    logic                    accept;
    logic                    exec_en;
    logic                    wb_en;
    logic                    is_cmp;

    instr_t                  instr_d;
    logic [WIDTH-1:0]        regs [NREGS];

    logic [OPCODE_WIDTH-1:0] op_q;
    logic [1:0]              rd_q;
    logic [WIDTH-1:0]        a_q;
    logic [WIDTH-1:0]        b_q;

    logic [WIDTH-1:0]        alu_y;
    logic                    alu_c;
    logic                    alu_g;
    logic                    alu_e;

    logic [WIDTH-1:0]        y_q;
    logic                    c_q;
    logic                    g_q;
    logic                    e_q;

    assign instr_d  = instr_t'(instr);
    assign dbg_data = regs[dbg_addr];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: IDLE waits for an offer, EXEC and WB each last one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (instr_valid) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_WB;
            ST_WB:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded controls
    always_comb begin
        instr_ready = (state == ST_IDLE);
        accept      = instr_ready && instr_valid;
        exec_en     = (state == ST_EXEC);
        wb_en       = (state == ST_WB);
        is_cmp      = (op_q == OPCODE_WIDTH'(OP_CMP));
    end

    // Operand latch: capture op, destination and both operands at acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0;
            rd_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (accept) begin
            op_q <= OPCODE_WIDTH'(instr_d.op);
            rd_q <= instr_d.rd;
            a_q  <= regs[instr_d.rd];
            b_q  <= instr_d.imm_sel ? WIDTH'(instr_d.imm) : regs[instr_d.rsb];
        end
    end

    alu #(
        .WIDTH        (WIDTH),
        .OPCODE_WIDTH (OPCODE_WIDTH)
    ) u_alu (
        .op    (op_q),
        .a     (a_q),
        .b     (b_q),
        .y     (alu_y),
        .carry (alu_c),
        .gt    (alu_g),
        .eq    (alu_e)
    );

    // ALU output register, loaded at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
            c_q <= 1'b0;
            g_q <= 1'b0;
            e_q <= 1'b0;
        end else if (exec_en) begin
            y_q <= alu_y;
            c_q <= alu_c;
            g_q <= alu_g;
            e_q <= alu_e;
        end
    end

    // Retire at the end of WB: done pulse, result, flags {G,E,C}, register write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done   <= 1'b0;
            result <= '0;
            flags  <= 3'b000;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            done <= wb_en;
            if (wb_en) begin
                result <= y_q;
                if (is_cmp) begin
                    // compare touches only G/E and never the register file
                    flags[2:1] <= {g_q, e_q};
                end else begin
                    flags[0]   <= c_q;
                    regs[rd_q] <= y_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: reset, ALU ops, carry, compare, shifts, hazards, abort.
// Latency: measures accept-to-done per instruction (expected 2 cycles).
// Backpressure: holds instr_valid high to confirm one accept per 3 cycles.
module tb_exec_unit;

    localparam logic [2:0] OPC_ADD = 3'b000;
    localparam logic [2:0] OPC_SUB = 3'b001;
    localparam logic [2:0] OPC_AND = 3'b010;
    localparam logic [2:0] OPC_OR  = 3'b011;
    localparam logic [2:0] OPC_XOR = 3'b100;
    localparam logic [2:0] OPC_CMP = 3'b101;
    localparam logic [2:0] OPC_SHL = 3'b110;
    localparam logic [2:0] OPC_SHR = 3'b111;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        done;
    logic [7:0]  result;
    logic [2:0]  flags;
    logic [1:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int checks   = 0;
    int failures = 0;

    exec_unit #(
        .WIDTH        (8),
        .OPCODE_WIDTH (3),
        .NREGS        (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .done        (done),
        .result      (result),
        .flags       (flags),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] rsb, input logic sel,
                                        input logic [7:0] imm);
        return {op, rd, rsb, sel, imm};
    endfunction

    // Offer one instruction, then report cycles from accept edge to done (-1 if none)
    task automatic run_instr(input logic [15:0] ins, output int lat);
        int w;
        lat = -1;
        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        w = 0;
        while (instr_ready !== 1'b1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        for (int k = 1; k <= 6 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) lat = k;
        end
    endtask

    task automatic peek(input logic [1:0] a, output logic [7:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        dbg_addr    = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_in_reset got=%b exp=1", instr_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            peek(2'(i), v);
            checks++;
            if (v !== 8'h00) begin
                failures++;
                $display("FAIL reset_reg%0d got=%h exp=00", i, v);
            end
        end
        checks++;
        if (flags !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", flags); end
        checks++;
        if (instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++;
        if (result !== 8'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", result); end
    endtask

    task automatic test_add_carry();
        int lat;
        logic [7:0] v;
        run_instr(enc(OPC_ADD, 2'd1, 2'd0, 1'b1, 8'hF0), lat);
        peek(2'd1, v);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL add1_latency got=%0d exp=2", lat); end
        checks++;
        if (v !== 8'hF0) begin failures++; $display("FAIL add1_r1 got=%h exp=f0", v); end
        checks++;
        if (flags !== 3'b000) begin failures++; $display("FAIL add1_flags got=%b exp=000", flags); end
        checks++;
        if (result !== 8'hF0) begin failures++; $display("FAIL add1_result got=%h exp=f0", result); end
        run_instr(enc(OPC_ADD, 2'd1, 2'd0, 1'b1, 8'h20), lat);
        peek(2'd1, v);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL add2_latency got=%0d exp=2", lat); end
        checks++;
        if (v !== 8'h10) begin failures++; $display("FAIL add2_r1 got=%h exp=10", v); end
        checks++;
        if (flags !== 3'b001) begin failures++; $display("FAIL add2_flags got=%b exp=001", flags); end
        checks++;
        if (result !== 8'h10) begin failures++; $display("FAIL add2_result got=%h exp=10", result); end
    endtask

    task automatic test_alu_ops();
        int lat;
        logic [7:0] v;
        run_instr(enc(OPC_SUB, 2'd0, 2'd0, 1'b1, 8'h01), lat);
        peek(2'd0, v);
        checks++;
        if (v !== 8'hFF) begin failures++; $display("FAIL sub_wrap_r0 got=%h exp=ff", v); end
        checks++;
        if (flags !== 3'b000) begin failures++; $display("FAIL sub_flags got=%b exp=000", flags); end
        run_instr(enc(OPC_XOR, 2'd0, 2'd0, 1'b1, 8'h0F), lat);
        peek(2'd0, v);
        checks++;
        if (v !== 8'hF0) begin failures++; $display("FAIL xor_r0 got=%h exp=f0", v); end
        run_instr(enc(OPC_OR, 2'd0, 2'd0, 1'b1, 8'h05), lat);
        peek(2'd0, v);
        checks++;
        if (v !== 8'hF5) begin failures++; $display("FAIL or_r0 got=%h exp=f5", v); end
        run_instr(enc(OPC_AND, 2'd0, 2'd0, 1'b1, 8'h3C), lat);
        peek(2'd0, v);
        checks++;
        if (v !== 8'h34) begin failures++; $display("FAIL and_r0 got=%h exp=34", v); end
        run_instr(enc(OPC_ADD, 2'd3, 2'd0, 1'b0, 8'h00), lat);
        peek(2'd3, v);
        checks++;
        if (v !== 8'h34) begin failures++; $display("FAIL add_reg_r3 got=%h exp=34", v); end
        run_instr(enc(OPC_ADD, 2'd3, 2'd3, 1'b0, 8'h00), lat);
        peek(2'd3, v);
        checks++;
        if (v !== 8'h68) begin failures++; $display("FAIL add_self_r3 got=%h exp=68", v); end
    endtask

    task automatic test_cmp();
        int lat;
        logic [7:0] v;
        run_instr(enc(OPC_ADD, 2'd2, 2'd0, 1'b1, 8'h05), lat);
        run_instr(enc(OPC_AND, 2'd3, 2'd0, 1'b1, 8'h00), lat);
        run_instr(enc(OPC_ADD, 2'd3, 2'd0, 1'b1, 8'h05), lat);
        run_instr(enc(OPC_ADD, 2'd1, 2'd0, 1'b1, 8'hF0), lat);
        checks++;
        if (flags !== 3'b001) begin failures++; $display("FAIL cmp_pre_flags got=%b exp=001", flags); end
        run_instr(enc(OPC_CMP, 2'd2, 2'd3, 1'b0, 8'h00), lat);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL cmp_eq_latency got=%0d exp=2", lat); end
        checks++;
        if (flags !== 3'b011) begin failures++; $display("FAIL cmp_eq_flags got=%b exp=011", flags); end
        peek(2'd2, v);
        checks++;
        if (v !== 8'h05) begin failures++; $display("FAIL cmp_eq_r2 got=%h exp=05", v); end
        peek(2'd3, v);
        checks++;
        if (v !== 8'h05) begin failures++; $display("FAIL cmp_eq_r3 got=%h exp=05", v); end
        run_instr(enc(OPC_CMP, 2'd2, 2'd0, 1'b1, 8'h03), lat);
        checks++;
        if (flags !== 3'b101) begin failures++; $display("FAIL cmp_gt_flags got=%b exp=101", flags); end
        peek(2'd2, v);
        checks++;
        if (v !== 8'h05) begin failures++; $display("FAIL cmp_gt_r2 got=%h exp=05", v); end
    endtask

    task automatic test_shift();
        int lat;
        logic [7:0] v;
        run_instr(enc(OPC_ADD, 2'd1, 2'd0, 1'b1, 8'h81), lat);
        peek(2'd1, v);
        checks++;
        if (v !== 8'h81) begin failures++; $display("FAIL shift_load_r1 got=%h exp=81", v); end
        run_instr(enc(OPC_SHL, 2'd1, 2'd0, 1'b1, 8'h01), lat);
        peek(2'd1, v);
        checks++;
        if (v !== 8'h02) begin failures++; $display("FAIL shl_r1 got=%h exp=02", v); end
        checks++;
        if (flags !== 3'b100) begin failures++; $display("FAIL shl_flags got=%b exp=100", flags); end
        run_instr(enc(OPC_SHR, 2'd1, 2'd0, 1'b1, 8'h08), lat);
        peek(2'd1, v);
        checks++;
        if (v !== 8'h00) begin failures++; $display("FAIL shr8_r1 got=%h exp=00", v); end
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL shr8_latency got=%0d exp=2", lat); end
    endtask

    task automatic test_back_to_back();
        int dn;
        logic exp_rdy;
        logic [7:0] v;
        dn = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) begin
                instr       = enc(OPC_ADD, 2'd2, 2'd0, 1'b1, 8'h01);
                instr_valid = 1'b1;
            end
            exp_rdy = ((k % 3) == 0);
            checks++;
            if (instr_ready !== exp_rdy) begin
                failures++;
                $display("FAIL b2b_ready_k%0d got=%b exp=%b", k, instr_ready, exp_rdy);
            end
            @(posedge clk);
            #1;
            if (done === 1'b1) dn++;
        end
        @(negedge clk);
        instr_valid = 1'b0;
        checks++;
        if (dn !== 4) begin failures++; $display("FAIL b2b_done_count got=%0d exp=4", dn); end
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dn++;
        end
        checks++;
        if (dn !== 4) begin failures++; $display("FAIL b2b_no_queue got=%0d exp=4", dn); end
        peek(2'd2, v);
        checks++;
        if (v !== 8'h09) begin failures++; $display("FAIL b2b_r2 got=%h exp=09", v); end
    endtask

    task automatic test_reset_abort();
        int dn;
        logic [7:0] v;
        dn = 0;
        @(negedge clk);
        instr       = enc(OPC_ADD, 2'd1, 2'd0, 1'b1, 8'h01);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin failures++; $display("FAIL abort_ready_in_reset got=%b exp=1", instr_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dn++;
        end
        checks++;
        if (dn !== 0) begin failures++; $display("FAIL abort_done_count got=%0d exp=0", dn); end
        peek(2'd1, v);
        checks++;
        if (v !== 8'h00) begin failures++; $display("FAIL abort_r1 got=%h exp=00", v); end
        checks++;
        if (flags !== 3'b000) begin failures++; $display("FAIL abort_flags got=%b exp=000", flags); end
        checks++;
        if (instr_ready !== 1'b1) begin failures++; $display("FAIL abort_idle got=%b exp=1", instr_ready); end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_alu_ops();
        test_cmp();
        test_shift();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning datapath and register width in bits.
REQ-002 The block SHALL have parameter OPCODE_WIDTH, default 3, meaning ALU opcode width in bits.
REQ-003 The block SHALL have parameter NREGS, default 4, meaning the number of general registers (fixed at 4 for 2-bit indices).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  Single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  Asynchronous active-low reset.
REQ-007 instr_valid  input  1  Instruction offered.
REQ-008 instr_ready  output  1  Block can accept an instruction.
REQ-009 instr  input  16  Instruction word: [15:13] op, [12:11] rd/rsA, [10:9] rsB, [8] imm_sel, [7:0] imm.
REQ-010 done  output  1  One-cycle pulse when an instruction retires.
REQ-011 result  output  WIDTH  Registered ALU result of the last retired instruction.
REQ-012 flags  output  3  Registered status {G, E, C}.
REQ-013 dbg_addr  input  2  Register-file observation index.
REQ-014 dbg_data  output  WIDTH  Combinational read of regs[dbg_addr].

Function
REQ-015 The opcode map SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 CMP, 110 SHL, 111 SHR.
REQ-016 The FSM SHALL have the states IDLE, EXEC and WB, with transitions IDLE->EXEC on instr_valid, EXEC->WB unconditionally, and WB->IDLE unconditionally.
REQ-017 instr_ready SHALL be 1 only in IDLE, and an instruction SHALL be accepted only on a cycle where instr_valid and instr_ready are both 1.
REQ-018 On acceptance, the block SHALL latch op, rd, operand A = regs[rd], and operand B = imm_sel ? imm : regs[rsB].
REQ-019 In EXEC, the latched operands and op SHALL drive the ALU, and the ALU outputs SHALL be registered at the end of EXEC.
REQ-020 In WB, the block SHALL pulse done, update result, write regs[rd] for every op except CMP, and update flags.
REQ-021 Flag C SHALL be updated on every non-CMP op with the ALU carry, which is 0 for non-ADD ops; G and E SHALL hold their values on non-CMP ops.
REQ-022 On CMP, G and E SHALL be updated from the unsigned compare, C SHALL hold, and no register write SHALL occur.
REQ-023 Latency SHALL be exactly 2 cycles: an instruction accepted at edge N gives done high in cycle N+2, and the next accept is possible at edge N+3.
REQ-024 All arithmetic SHALL be unsigned and modulo 2^WIDTH; the ADD carry SHALL be bit WIDTH of the sum; SUB SHALL wrap with no borrow flag.
REQ-025 A shift amount of WIDTH or more SHALL yield 0.
REQ-026 The register write SHALL be visible on dbg_data in the cycle after WB.
REQ-027 An instruction that reads the rd just written SHALL see the new value, because acceptance follows WB.
REQ-028 instr_valid SHALL be ignored outside IDLE, and no instruction SHALL be queued.

Reset
REQ-029 While rst_n=0, the block SHALL set state IDLE, all regs to 0, result 0, flags 000, done 0, and instr_ready 1 after the FSM is in IDLE.
REQ-030 A reset asserted in EXEC or WB SHALL abort the instruction with no register or flag write and no done pulse.
REQ-031 Release of rst_n SHALL be taken synchronously to clk at the integration level.

Structure
REQ-032 The opcode encodings, the instruction field positions and the FSM state encoding SHALL be defined in a shared package exec_pkg.
REQ-033 The block SHALL instantiate the existing alu module as its single sub-module, with WIDTH and OPCODE_WIDTH passed through.
REQ-034 The register file, FSM and operand latches SHALL reside in exec_unit.

Verification
REQ-035 Scenario: reset, then read all regs via dbg -> all 0x00, flags 000, instr_ready 1.
REQ-036 Scenario: ADD r1 imm 0xF0, then ADD r1 imm 0x20 -> r1=0xF0 with C=0, then r1=0x10 with C=1, and done exactly 2 cycles after each accept.
REQ-037 Scenario: r2=0x05, r3=0x05, CMP r2,r3, then CMP r2 imm 0x03 -> flags E=1 G=0, then G=1 E=0, with C unchanged and r2 unchanged.
REQ-038 Scenario: r1=0x81, SHL r1 imm 1, then SHR imm 8 -> r1=0x02, then 0x00.
REQ-039 Scenario: instr_valid held high continuously -> accept only in IDLE, with one instruction per 3 cycles.
REQ-040 Scenario: rst_n pulsed low during EXEC of ADD r1 imm 0x01 -> no done, r1=0x00, state IDLE.
